// File: rtl/fft_frame_sequencer_if.sv
// rtl/fft_frame_sequencer_if.sv - signal bundle between the frame sequencer and its codec/FFT neighbours
//
// Purpose: groups the sample stream, FFT input-buffer write port, FFT core
// handshake, bin readout and status/result signals. Clock and reset stay
// outside as plain ports of the sequencer.
//
// Modports:
//   master - the sequencer: takes samples and core beats, drives buffer
//            writes, fft_start, results and flags.
//   slave  - the environment (codec, FFT core, host): the mirror image.
interface fft_frame_sequencer_if #(
  parameter int LOG_N = 9
);
  logic                    enable;
  logic                    sample_valid;
  logic signed [17:0]      sample_in;

  logic                    fft_in_valid;
  logic [LOG_N-1:0]        fft_in_addr;
  logic signed [17:0]      fft_in_data;
  logic                    fft_start;
  logic                    fft_done;

  logic                    fft_out_valid;
  logic [LOG_N-1:0]        fft_out_addr;
  logic signed [17:0]      fft_out_real;
  logic signed [17:0]      fft_out_imag;

  logic [LOG_N-1:0]        peak_bin;
  logic [18:0]             peak_mag;
  logic                    result_valid;
  logic                    busy;
  logic                    overrun;
  logic                    timeout_err;

  modport master (
    input  enable, sample_valid, sample_in, fft_done,
           fft_out_valid, fft_out_addr, fft_out_real, fft_out_imag,
    output fft_in_valid, fft_in_addr, fft_in_data, fft_start,
           peak_bin, peak_mag, result_valid, busy, overrun, timeout_err
  );

  modport slave (
    output enable, sample_valid, sample_in, fft_done,
           fft_out_valid, fft_out_addr, fft_out_real, fft_out_imag,
    input  fft_in_valid, fft_in_addr, fft_in_data, fft_start,
           peak_bin, peak_mag, result_valid, busy, overrun, timeout_err
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - collects a frame of codec samples, runs the FFT core and reports the peak bin
//
// Purpose: loads N = 2**LOG_N samples into the FFT input buffer, pulses
// fft_start, waits (bounded by TIMEOUT cycles) for fft_done, then scans the
// returned bins 1..N/2-1 for the largest |re|+|im| and reports it.
//
// Ports:
//   clk    - rising-edge system clock
//   reset  - synchronous, active-low reset
//   bus    - fft_frame_sequencer_if.master: sample stream in, FFT buffer
//            write port and start/done handshake, bin readout in,
//            peak_bin/peak_mag/result_valid, busy, overrun, timeout_err out
module fft_frame_sequencer #(
  parameter int LOG_N   = 9,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_frame_sequencer_if.master bus
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_REPORT
  } state_t;

  state_t             state_q, state_d;
  logic [LOG_N-1:0]   load_cnt_q, load_cnt_d;
  logic [WCW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [LOG_N-1:0]   max_bin_q, max_bin_d;
  logic [18:0]        max_mag_q, max_mag_d;

  logic               fft_in_valid_q, fft_in_valid_d;
  logic [LOG_N-1:0]   fft_in_addr_q, fft_in_addr_d;
  logic [17:0]        fft_in_data_q, fft_in_data_d;
  logic               fft_start_q, fft_start_d;
  logic [LOG_N-1:0]   peak_bin_q, peak_bin_d;
  logic [18:0]        peak_mag_q, peak_mag_d;
  logic               result_valid_q, result_valid_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;
  logic               timeout_err_q, timeout_err_d;

  // Magnitude of the current bin beat. Absolute values are taken as 18-bit
  // unsigned so that -131072 maps to 131072; the sum needs the 19th bit.
  logic [17:0]        re_abs, im_abs;
  logic [18:0]        beat_mag;
  logic               beat_cand;
  logic               beat_last;

  always_comb begin
    re_abs    = bus.fft_out_real[17] ? $unsigned(-bus.fft_out_real) : $unsigned(bus.fft_out_real);
    im_abs    = bus.fft_out_imag[17] ? $unsigned(-bus.fft_out_imag) : $unsigned(bus.fft_out_imag);
    beat_mag  = {1'b0, re_abs} + {1'b0, im_abs};
    // Bins 1..N/2-1: nonzero index with the top address bit clear.
    beat_cand = (bus.fft_out_addr != '0) && !bus.fft_out_addr[LOG_N-1];
    beat_last = &bus.fft_out_addr;
  end

  always_comb begin
    state_d        = state_q;
    load_cnt_d     = load_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    max_bin_d      = max_bin_q;
    max_mag_d      = max_mag_q;
    fft_in_valid_d = 1'b0;
    fft_in_addr_d  = fft_in_addr_q;
    fft_in_data_d  = fft_in_data_q;
    fft_start_d    = 1'b0;
    peak_bin_d     = peak_bin_q;
    peak_mag_d     = peak_mag_q;
    result_valid_d = 1'b0;
    overrun_d      = overrun_q;
    timeout_err_d  = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        // Samples arriving here are simply not wanted; they are no overrun.
        if (bus.enable) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (bus.sample_valid) begin
          fft_in_valid_d = 1'b1;
          fft_in_addr_d  = load_cnt_q;
          fft_in_data_d  = bus.sample_in;
          load_cnt_d     = load_cnt_q + LOG_N'(1);
          // The all-ones address is the last write; the counter wraps to 0.
          if (&load_cnt_q) begin
            state_d = S_START;
          end
        end
      end

      S_START: begin
        // fft_start rises as the last buffer write retires, so the core
        // never sees a start before its input buffer is complete.
        fft_start_d = 1'b1;
        wait_cnt_d  = '0;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        if (bus.fft_done) begin
          max_bin_d = '0;
          max_mag_d = '0;
          state_d   = S_DRAIN;
        end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end

      S_DRAIN: begin
        if (bus.fft_out_valid) begin
          // Strictly greater keeps the lower index on ties.
          if (beat_cand && (beat_mag > max_mag_q)) begin
            max_bin_d = bus.fft_out_addr;
            max_mag_d = beat_mag;
          end
          // The result registers load on the final beat, including that
          // beat's contribution, so result_valid is high during REPORT,
          // one cycle after the last beat.
          if (beat_last) begin
            peak_bin_d     = max_bin_d;
            peak_mag_d     = max_mag_d;
            result_valid_d = 1'b1;
            state_d        = S_REPORT;
          end
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.sample_valid &&
        (state_q == S_START || state_q == S_WAIT ||
         state_q == S_DRAIN || state_q == S_REPORT)) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      load_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      max_bin_q      <= '0;
      max_mag_q      <= '0;
      fft_in_valid_q <= 1'b0;
      fft_in_addr_q  <= '0;
      fft_in_data_q  <= '0;
      fft_start_q    <= 1'b0;
      peak_bin_q     <= '0;
      peak_mag_q     <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_cnt_q     <= load_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      max_bin_q      <= max_bin_d;
      max_mag_q      <= max_mag_d;
      fft_in_valid_q <= fft_in_valid_d;
      fft_in_addr_q  <= fft_in_addr_d;
      fft_in_data_q  <= fft_in_data_d;
      fft_start_q    <= fft_start_d;
      peak_bin_q     <= peak_bin_d;
      peak_mag_q     <= peak_mag_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign bus.fft_in_valid = fft_in_valid_q;
  assign bus.fft_in_addr  = fft_in_addr_q;
  assign bus.fft_in_data  = fft_in_data_q;
  assign bus.fft_start    = fft_start_q;
  assign bus.peak_bin     = peak_bin_q;
  assign bus.peak_mag     = peak_mag_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - scoreboard bench for the FFT frame sequencer
module tb_fft_frame_sequencer;

  localparam int LOG_N   = 9;
  localparam int N       = 512;
  localparam int TIMEOUT = 4096;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft_frame_sequencer_if #(.LOG_N(LOG_N)) bus();

  fft_frame_sequencer #(.LOG_N(LOG_N), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;

  logic [26:0] exp_wr[$];   // {addr, data}
  logic [27:0] exp_res[$];  // {bin, mag}
  logic [26:0] mon_wr;
  logic [27:0] mon_res;

  int re_tab[N];
  int im_tab[N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard side: every buffer write and every result is matched
  // against what the stimulus queued.
  always @(negedge clk) begin
    if (bus.fft_start) start_cnt++;
    if (bus.fft_in_valid) begin
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        mon_wr = exp_wr.pop_front();
        check("wr_addr", bus.fft_in_addr, mon_wr[26:18]);
        check("wr_data", $unsigned(bus.fft_in_data), mon_wr[17:0]);
      end
    end
    if (bus.result_valid) begin
      if (exp_res.size() == 0) check("res_unexpected", 1, 0);
      else begin
        mon_res = exp_res.pop_front();
        check("res_bin", bus.peak_bin, mon_res[27:19]);
        check("res_mag", bus.peak_mag, mon_res[18:0]);
      end
    end
  end

  function automatic logic [17:0] sine_sample(input int i);
    real r;
    r = 100000.0 * $sin(6.283185307 * 5.0 * i / 512.0);
    return 18'($rtoi(r));
  endfunction

  task automatic check_all_zero(input string pfx);
    check({pfx, "_in_valid"}, bus.fft_in_valid, 0);
    check({pfx, "_in_addr"}, bus.fft_in_addr, 0);
    check({pfx, "_in_data"}, $unsigned(bus.fft_in_data), 0);
    check({pfx, "_start"}, bus.fft_start, 0);
    check({pfx, "_peak_bin"}, bus.peak_bin, 0);
    check({pfx, "_peak_mag"}, bus.peak_mag, 0);
    check({pfx, "_res_valid"}, bus.result_valid, 0);
    check({pfx, "_busy"}, bus.busy, 0);
    check({pfx, "_overrun"}, bus.overrun, 0);
    check({pfx, "_timeout"}, bus.timeout_err, 0);
  endtask

  task automatic fill_small();
    for (int a = 0; a < N; a++) begin
      re_tab[a] = int'($urandom_range(100)) - 50;
      im_tab[a] = int'($urandom_range(100)) - 50;
    end
  endtask

  task automatic fill_zero();
    for (int a = 0; a < N; a++) begin
      re_tab[a] = 0;
      im_tab[a] = 0;
    end
  endtask

  // Enable is raised for one cycle only: the frame must not abort when it drops.
  task automatic begin_frame();
    bus.enable = 1'b1;
    @(negedge clk);
    bus.enable = 1'b0;
  endtask

  task automatic load_samples(input int n);
    for (int i = 0; i < n; i++) begin
      logic [17:0] s;
      s = sine_sample(i);
      bus.sample_valid = 1'b1;
      bus.sample_in    = s;
      exp_wr.push_back({9'(i), s});
      @(negedge clk);
      bus.sample_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20 && !bus.fft_start; i++) @(negedge clk);
    check("start_seen", bus.fft_start, 1);
  endtask

  task automatic drain_frame();
    repeat (3) @(negedge clk);
    bus.fft_done = 1'b1;
    @(negedge clk);
    bus.fft_done = 1'b0;
    for (int a = 0; a < N; a++) begin
      bus.fft_out_valid = 1'b1;
      bus.fft_out_addr  = 9'(a);
      bus.fft_out_real  = 18'(re_tab[a]);
      bus.fft_out_imag  = 18'(im_tab[a]);
      @(negedge clk);
    end
    bus.fft_out_valid = 1'b0;
    check("res_latency", bus.result_valid, 1);
    @(negedge clk);
    check("res_pulse_end", bus.result_valid, 0);
    check("busy_after_rpt", bus.busy, 0);
  endtask

  task automatic run_frame(input int exp_bin, input int exp_mag, input bit inject_overrun);
    int s0;
    s0 = start_cnt;
    begin_frame();
    load_samples(N);
    wait_start();
    if (inject_overrun) begin
      bus.sample_valid = 1'b1;
      bus.sample_in    = 18'h155;
      @(negedge clk);
      bus.sample_valid = 1'b0;
      check("ovr_set", bus.overrun, 1);
      check("ovr_no_write", bus.fft_in_valid, 0);
    end
    exp_res.push_back({9'(exp_bin), 19'(exp_mag)});
    drain_frame();
    check("start_pulses", start_cnt - s0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    bus.enable = 0; bus.sample_valid = 0; bus.sample_in = 0; bus.fft_done = 0;
    bus.fft_out_valid = 0; bus.fft_out_addr = 0; bus.fft_out_real = 0; bus.fft_out_imag = 0;

    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;
    @(negedge clk);

    // Stray traffic in IDLE with enable low is ignored.
    bus.sample_valid = 1'b1; bus.sample_in = 18'd77;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.fft_done = 1'b1;
    bus.fft_out_valid = 1'b1; bus.fft_out_addr = 9'd511; bus.fft_out_real = 18'd500;
    @(negedge clk);
    bus.fft_done = 1'b0; bus.fft_out_valid = 1'b0;
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_overrun", bus.overrun, 0);
    check("idle_result", bus.result_valid, 0);

    // Normal frame: bin 37 dominates.
    fill_small();
    re_tab[37] = 1000; im_tab[37] = -500;
    run_frame(37, 1500, 1'b0);
    check("a_overrun", bus.overrun, 0);

    // Ties and exclusions, with a sample dropped during WAIT.
    fill_small();
    re_tab[0]   = 4000;  im_tab[0]   = 0;
    re_tab[10]  = 2000;  im_tab[10]  = -2000;
    re_tab[20]  = -4000; im_tab[20]  = 0;
    re_tab[300] = 0;     im_tab[300] = 4000;
    re_tab[256] = 5000;  im_tab[256] = 0;
    run_frame(10, 4000, 1'b1);

    // All-zero candidates; DC and N/2 are large but excluded.
    fill_zero();
    re_tab[0] = 9000; re_tab[256] = -9000;
    run_frame(0, 0, 1'b0);
    check("ovr_sticky", bus.overrun, 1);

    // Extreme magnitudes.
    fill_zero();
    re_tab[5]   = -131072; im_tab[5]   = -131072;
    re_tab[6]   = 131071;  im_tab[6]   = -131072;
    re_tab[255] = 131071;  im_tab[255] = 131071;
    re_tab[400] = -131072; im_tab[400] = -131072;
    run_frame(5, 262144, 1'b0);
    repeat (10) @(negedge clk);
    check("hold_bin", bus.peak_bin, 5);
    check("hold_mag", bus.peak_mag, 262144);

    // Timeout: fft_done never comes.
    begin_frame();
    load_samples(N);
    wait_start();
    n = 0;
    while (bus.busy && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, TIMEOUT);
    check("to_flag", bus.timeout_err, 1);
    check("to_hold_bin", bus.peak_bin, 5);
    repeat (4) @(negedge clk);
    check("to_busy", bus.busy, 0);

    // Reset in the middle of a load.
    begin_frame();
    load_samples(200);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    reset = 1'b1;
    exp_wr.delete();
    @(negedge clk);

    // Fresh frame writes from address 0; bin 255 is the top candidate.
    fill_small();
    re_tab[37]  = 1000; im_tab[37]  = -500;
    re_tab[255] = 1000; im_tab[255] = -600;
    re_tab[256] = 3000;
    run_frame(255, 1600, 1'b0);
    check("e_timeout_clr", bus.timeout_err, 0);
    check("e_overrun_clr", bus.overrun, 0);

    repeat (3) @(negedge clk);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("res_queue_empty", exp_res.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
